// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode enum and flag bit positions for the pipelined ALU.
// Build option: ALU_SAT_EN (saturating ADD/SUB) is consumed by alu_core.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_PASS = 3'd5,
    OP_SHL  = 3'd6,
    OP_SHR  = 3'd7
  } alu_op_e;

  // Bit positions inside the 4-bit flags vector {N, V, C, Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath (op, a, b) -> (result, flags).
// Build option: define ALU_SAT_EN to make ADD/SUB saturate on signed overflow;
// when undefined, ADD/SUB wrap and no saturation logic exists.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  alu_op_e              op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [WIDTH-1:0]     result,
  output logic [NUM_FLAGS-1:0] flags
);

  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic [WIDTH-1:0] raw_res;
  logic             carry;
  logic             ovf;

  // Only the low SHW bits of b steer the shifters; upper bits are ignored.
  assign amt = b[SHW-1:0];

  // One extra bit on each side captures carry/borrow and the last shifted-out bit.
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign shl_ext  = {1'b0, a} << amt;
  assign shr_ext  = {a, 1'b0} >> amt;

  // Opcode decode: raw (wrapping) result, carry/borrow and signed overflow.
  always_comb begin
    raw_res = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    case (op)
      OP_ADD: begin
        raw_res = sum_ext[WIDTH-1:0];
        carry   = sum_ext[WIDTH];
        ovf     = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        raw_res = diff_ext[WIDTH-1:0];
        carry   = diff_ext[WIDTH];
        ovf     = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  raw_res = a & b;
      OP_OR:   raw_res = a | b;
      OP_XOR:  raw_res = a ^ b;
      OP_PASS: raw_res = a;
      OP_SHL: begin
        raw_res = shl_ext[WIDTH-1:0];
        carry   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        raw_res = shr_ext[WIDTH:1];
        carry   = shr_ext[0];
      end
      default: raw_res = '0;
    endcase
  end

`ifdef ALU_SAT_EN
  // Clamp to the signed extreme in the direction of operand a's sign on overflow.
  always_comb begin
    result = raw_res;
    if (ovf) begin
      result = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  // Wrapping arithmetic: the raw result goes straight out.
  always_comb begin
    result = raw_res;
  end
`endif

  // Flags derive N/Z from the final result; C keeps the raw carry/borrow.
  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_C] = carry;
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU pipeline (operand register -> result register).
// Build option: ALU_SAT_EN selects saturating ADD/SUB inside alu_core.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)  // derived; leave at default
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  alu_op_e              op,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     alu_output,
  output logic [NUM_FLAGS-1:0] flags
);

  logic                 s1_valid_reg;
  alu_op_e              s1_op_reg;
  logic [WIDTH-1:0]     s1_a_reg;
  logic [WIDTH-1:0]     s1_b_reg;
  logic                 s2_valid_reg;
  logic [WIDTH-1:0]     s2_result_reg;
  logic [NUM_FLAGS-1:0] s2_flags_reg;

  logic                 s2_load;
  logic [WIDTH-1:0]     core_result;
  logic [NUM_FLAGS-1:0] core_flags;

  // S2 may take a new value when empty or when its beat leaves this cycle;
  // S1 may accept when empty or when it can drain into S2.
  assign s2_load  = !s2_valid_reg || out_ready;
  assign in_ready = !s1_valid_reg || s2_load;

  alu_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .op     (s1_op_reg),
    .a      (s1_a_reg),
    .b      (s1_b_reg),
    .result (core_result),
    .flags  (core_flags)
  );

  // Operand stage: capture an accepted beat, otherwise empty out once S2 takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_op_reg    <= OP_ADD;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid_reg <= 1'b1;
      s1_op_reg    <= op;
      s1_a_reg     <= A;
      s1_b_reg     <= B;
    end else if (s2_load) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // Result stage: advance on s2_load; data only changes when S1 holds a real beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_reg  <= 1'b0;
      s2_result_reg <= '0;
      s2_flags_reg  <= '0;
    end else if (s2_load) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_result_reg <= core_result;
        s2_flags_reg  <= core_flags;
      end
    end
  end

  assign out_valid  = s2_valid_reg;
  assign alu_output = s2_result_reg;
  assign flags      = s2_flags_reg;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe (WIDTH=16).
// Honours ALU_SAT_EN for the signed-overflow expectations.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W = 16;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  alu_op_e       op;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  alu_output;
  logic [3:0]    flags;

  int checks;
  int failures;

  alu_pipe #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_output (alu_output),
    .flags      (flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    op = OP_ADD;
    A = '0;
    B = '0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_output !== 16'h0000 || flags !== 4'h0) begin
      failures++;
      $display("FAIL reset_state: got out_valid=%b res=%h flags=%h, expected 0/0000/0",
               out_valid, alu_output, flags);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b, expected 1/0",
               in_ready, out_valid);
    end
    $display("reset: released");
  endtask

  // Single beat on an empty pipe: no result after one edge, result after two.
  task automatic test_single(input string name, input alu_op_e t_op,
                             input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                             input logic [W-1:0] er, input logic [3:0] ef);
    out_ready = 1'b1;
    op = t_op;
    A = ta;
    B = tb_v;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_in_ready: got %b, expected 1", name, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_early: got out_valid=%b one cycle after accept, expected 0", name, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || alu_output !== er || flags !== ef) begin
      failures++;
      $display("FAIL %s: got valid=%b res=%h flags=%h, expected valid=1 res=%h flags=%h",
               name, out_valid, alu_output, flags, er, ef);
    end
    $display("beat %s: A=%h B=%h -> res=%h flags=%h", name, ta, tb_v, alu_output, flags);
    @(posedge clk);
    #1;
  endtask

  task automatic test_arith();
    test_single("add_basic", OP_ADD, 16'h00A4, 16'h003B, 16'h00DF, 4'h0);
    test_single("sub_basic", OP_SUB, 16'h00A4, 16'h003B, 16'h0069, 4'h0);
    test_single("sub_borrow", OP_SUB, 16'h0001, 16'h0002, 16'hFFFF, 4'hA);
    test_single("add_carry_zero", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'h3);
  endtask

  task automatic test_overflow();
`ifdef ALU_SAT_EN
    test_single("add_pos_ovf", OP_ADD, 16'h7FFF, 16'h0001, 16'h7FFF, 4'h4);
    test_single("add_neg_ovf", OP_ADD, 16'h8000, 16'hFFFF, 16'h8000, 4'hE);
    test_single("sub_pos_ovf", OP_SUB, 16'h7FFF, 16'hFFFF, 16'h7FFF, 4'h6);
`else
    test_single("add_pos_ovf", OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 4'hC);
    test_single("add_neg_ovf", OP_ADD, 16'h8000, 16'hFFFF, 16'h7FFF, 4'h6);
    test_single("sub_pos_ovf", OP_SUB, 16'h7FFF, 16'hFFFF, 16'h8000, 4'hE);
`endif
  endtask

  task automatic test_logic_shift();
    test_single("pass", OP_PASS, 16'h0022, 16'h1234, 16'h0022, 4'h0);
    test_single("shl_upper_b_ignored", OP_SHL, 16'h8001, 16'h0011, 16'h0002, 4'h2);
    test_single("shr_by1", OP_SHR, 16'h0003, 16'h0001, 16'h0001, 4'h2);
    test_single("shr_by0", OP_SHR, 16'h8001, 16'h0010, 16'h8001, 4'h8);
    test_single("shl_by15", OP_SHL, 16'h0003, 16'h000F, 16'h8000, 4'hA);
    test_single("xor_equal", OP_XOR, 16'h5A5A, 16'h5A5A, 16'h0000, 4'h1);
    test_single("and", OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'h0);
    test_single("or", OP_OR, 16'h8000, 16'h0001, 16'h8001, 4'h8);
  endtask

  // 20 beats on consecutive cycles; result j must appear exactly two edges after issue.
  task automatic test_back_to_back();
    logic [W-1:0] exp_res [20];
    logic [W-1:0] ta;
    for (int i = 0; i < 20; i++) begin
      ta = 16'(i * 16'h0101);
      exp_res[i] = 16'(ta + 16'h0010);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 22; cyc++) begin
      if (cyc >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || alu_output !== exp_res[cyc-2]) begin
          failures++;
          $display("FAIL b2b_beat%0d: got valid=%b res=%h, expected valid=1 res=%h",
                   cyc - 2, out_valid, alu_output, exp_res[cyc-2]);
        end
        $display("b2b beat %0d: res=%h", cyc - 2, alu_output);
      end else begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL b2b_latency_cycle%0d: got out_valid=%b, expected 0", cyc, out_valid);
        end
      end
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_in_ready_cycle%0d: got %b, expected 1", cyc, in_ready);
      end
      if (cyc < 20) begin
        in_valid = 1'b1;
        op = OP_ADD;
        A = 16'(cyc * 16'h0101);
        B = 16'h0010;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Random stalls; scoreboard checks order/loss/duplication, hold stability and in_ready.
  task automatic test_backpressure();
    logic [W-1:0] sb_q[$];
    logic [W-1:0] prev_out;
    logic [W-1:0] exp_v;
    logic         prev_stall;
    logic         acc;
    logic         emit;
    logic         exp_ready;
    int           sent;
    int           recvd;
    int           occ;
    int           phase_left;
    sent = 0;
    recvd = 0;
    occ = 0;
    phase_left = 0;
    prev_stall = 1'b0;
    prev_out = '0;
    acc = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (acc) in_valid = 1'b0;
      if (phase_left == 0) begin
        if (out_ready) begin
          out_ready = 1'b0;
          phase_left = int'($urandom_range(1, 5));
        end else begin
          out_ready = 1'b1;
          phase_left = int'($urandom_range(1, 3));
        end
      end
      phase_left--;
      if (!in_valid && sent < 30 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        op = OP_ADD;
        A = 16'(sent * 3);
        B = 16'h0100;
      end
      #2;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || alu_output !== prev_out) begin
          failures++;
          $display("FAIL bp_hold_cycle%0d: got valid=%b res=%h, expected valid=1 res=%h",
                   cyc, out_valid, alu_output, prev_out);
        end
      end
      exp_ready = !(occ == 2 && !out_ready);
      checks++;
      if (in_ready !== exp_ready) begin
        failures++;
        $display("FAIL bp_in_ready_cycle%0d: got %b, expected %b (occupancy %0d)",
                 cyc, in_ready, exp_ready, occ);
      end
      acc  = in_valid && in_ready;
      emit = out_valid && out_ready;
      if (emit) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL bp_unexpected_beat: got res=%h, expected no beat", alu_output);
        end else begin
          exp_v = sb_q.pop_front();
          if (alu_output !== exp_v) begin
            failures++;
            $display("FAIL bp_order_beat%0d: got res=%h, expected res=%h", recvd, alu_output, exp_v);
          end
          $display("bp beat %0d: res=%h", recvd, alu_output);
        end
        recvd++;
      end
      if (acc) begin
        sb_q.push_back(16'(A + B));
        sent++;
      end
      occ = occ + (acc ? 1 : 0) - (emit ? 1 : 0);
      prev_stall = out_valid && !out_ready;
      prev_out = alu_output;
      if (recvd >= 30) break;
      @(posedge clk);
      #1;
    end
    checks++;
    if (recvd != 30 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL bp_total: got %0d beats received with %0d outstanding, expected 30 and 0",
               recvd, sb_q.size());
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Fill both stages under backpressure, then reset between clock edges.
  task automatic test_reset_midstream();
    out_ready = 1'b0;
    in_valid = 1'b1;
    op = OP_SUB;
    A = 16'h0001;
    B = 16'h0002;
    @(posedge clk);
    #1;
    op = OP_ADD;
    A = 16'h00A4;
    B = 16'h003B;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_output !== 16'hFFFF || flags !== 4'hA) begin
      failures++;
      $display("FAIL rst_mid_full: got valid=%b in_ready=%b res=%h flags=%h, expected 1/0/ffff/a",
               out_valid, in_ready, alu_output, flags);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_output !== 16'h0000 || flags !== 4'h0) begin
      failures++;
      $display("FAIL rst_mid_async: got valid=%b res=%h flags=%h, expected 0/0000/0",
               out_valid, alu_output, flags);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_in_ready: got %b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_discard: got out_valid=%b, expected 0", out_valid);
    end
    $display("reset mid-stream: pipeline flushed");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_arith();
    test_overflow();
    test_logic_shift();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_single("post_reset_add", OP_ADD, 16'h1234, 16'h0001, 16'h1235, 4'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the 16-bit add/subtract ALU on the APB datapath. Takes operand pairs plus a 3-bit opcode through a valid/ready handshake. Produces a registered result and status flags two cycles later. Supports full throughput and backpressure, and sits between the APB register file and the result/status registers.

## Interface
- `WIDTH`, 16: operand and result width in bits; must be at least 4.
- `SHW`, `$clog2(WIDTH)`: shift-amount width (derived; do not override).
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand beat offered.
- `in_ready` out 1: block accepts the beat this cycle.
- `op` in 3: opcode (`alu_pkg::alu_op_e`).
- `A` in WIDTH: operand A.
- `B` in WIDTH: operand B.
- `out_valid` out 1: result beat offered.
- `out_ready` in 1: consumer accepts the result this cycle.
- `alu_output` out WIDTH: result.
- `flags` out 4: {N, V, C, Z}.

## Operation
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 PASS: A; this replaces the former "enable low" behaviour.
  - 6 SHL: A << B[SHW-1:0].
  - 7 SHR: logical A >> B[SHW-1:0].
- Arithmetic is computed at WIDTH+1 bits. The result is the low WIDTH bits (wraps).
- Shift amount uses only B[SHW-1:0]. Upper B bits are ignored. For non-power-of-2 WIDTH, an amount ≥ WIDTH gives 0.
- Flags:
  - Z = (result == 0).
  - N = result[WIDTH-1].
  - C: ADD gives the carry-out. SUB gives the borrow, i.e. A < B unsigned. SHL gives the last bit shifted out. SHR gives the last bit shifted out. Shift by 0 gives C=0. Logic ops and PASS give 0.
  - V: signed overflow for ADD and SUB only; 0 otherwise.
- Pipeline, stage S1 (operand register):
  - Holds s1_valid, op, A, B.
  - Loads when in_valid && in_ready.
- Pipeline, stage S2 (result register):
  - Holds s2_valid, alu_output, flags.
  - Computation is combinational from S1 into S2.
- Advance rules:
  - s2_load = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_load (combinational; no combinational path from in_valid).
  - On s2_load: s2_valid ← s1_valid, and result/flags are captured only when s1_valid.
  - S1: on in_valid && in_ready, capture the beat with s1_valid=1. Otherwise, if s2_load, s1_valid ← 0.
- Holding rules:
  - While out_valid && !out_ready, alu_output and flags are held stable.
  - While in_valid && !in_ready, the upstream must hold its beat (AXI-style). The block does not check this.
- Beats are never dropped, duplicated or reordered. The capacity is 2 beats.
- Reset (asynchronous, any time, including mid-transfer):
  - s1_valid=0, s2_valid=0.
  - alu_output=0, flags=0, out_valid=0.
  - in_ready=1 as soon as reset is deasserted.
  - In-flight beats are discarded.

## Timing
- Latency: a beat accepted at edge k appears with out_valid=1 after edge k+1. It is visible in cycle k+1→k+2 if unstalled.
- Throughput: 1 beat/cycle with out_ready held high.
- Backpressure:
  - With out_ready low, S2 holds.
  - S1 fills; in_ready then falls after one more accepted beat.
  - Re-raising out_ready restores in_ready in the same cycle. There is no bubble.
- Simultaneous events:
  - Accept and emit in the same cycle are both legal with a full pipeline when out_ready=1.
- All outputs are registered except in_ready.

## Configuration
- `ALU_SAT_EN` defined:
  - ADD/SUB saturate on signed overflow. Positive overflow gives 2^(WIDTH-1)−1; negative overflow gives −2^(WIDTH-1).
  - V is still set on a saturated result. C, Z and N are taken from the saturated result, except C keeps the raw carry/borrow.
- `ALU_SAT_EN` undefined: ADD/SUB wrap as above. No extra logic is built.

## Structure
- `alu_pkg`:
  - `alu_op_e` enum with values 0–7.
  - Flag bit-index localparams FLAG_Z=0, FLAG_C=1, FLAG_V=2, FLAG_N=3.
- Sub-module `alu_core`: purely combinational (op, A, B) → (result, flags), parametrised on WIDTH. It holds the `ALU_SAT_EN` logic.
- `alu_pipe` holds only the handshake and stage registers.

## Test plan
- Reset mid-stream: assert reset with both stages full → out_valid=0, alu_output=0 and flags=0 immediately; in_ready=1 after deassertion.
- WIDTH=16 arithmetic, one beat per op:
  - ADD 00A4+003B → 00DF, flags 0.
  - SUB 00A4−003B → 0069.
  - SUB 0001−0002 → FFFF with N=1, C=1.
  - ADD FFFF+0001 → 0000 with Z=1, C=1.
- Signed overflow:
  - ADD 7FFF+0001 → 8000, V=1, N=1 without `ALU_SAT_EN`.
  - The same beat → 7FFF, V=1 with `ALU_SAT_EN`.
- Logic/shift ops:
  - PASS A=0022 → 0022.
  - SHL 8001 by B=0011 (amount 1) → 0002, C=1.
  - SHR 0003 by 1 → 0001, C=1.
  - XOR equal operands → 0000, Z=1.
- Throughput: 20 back-to-back beats with out_ready=1 → 20 results in order, first at 2 cycles latency, then one per cycle.
- Backpressure:
  - Random out_ready stalls of 1–5 cycles → output stable while stalled, in_ready low only with both stages full.
  - Scoreboard shows no loss, duplication or reordering.
